// File: rtl/aes_pkg.sv
// Shared AES datapath types, sizes and GF(2^8) arithmetic.
package aes_pkg;

  localparam int NB_STATE_BYTES = 16;
  localparam int NB_WORD_BYTES  = 4;

  typedef logic [7:0]                   byte_t;
  typedef byte_t [NB_WORD_BYTES-1:0]    word_t;
  typedef byte_t [NB_STATE_BYTES-1:0]   state_t;

  typedef enum logic [1:0] {IDLE, ST_RUN, WD_RUN} fsm_e;

  // Side that wins when both requesters are valid in the same cycle.
  typedef enum logic {RR_WORD, RR_STATE} rr_e;

  // Multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic byte_t gf_mul(input byte_t a, input byte_t b);
    byte_t p;
    byte_t x;
    byte_t m;
    p = '0;
    x = a;
    m = b;
    for (int unsigned i = 0; i < 8; i++) begin
      if (m[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      m = {1'b0, m[7:1]};
    end
    return p;
  endfunction

endpackage

// File: rtl/subbyte.sv
// subbyte: one AES S-box lane (multiplicative inverse followed by the affine map).
module subbyte
  import aes_pkg::*;
(
  input  logic [7:0] din_i,
  output logic [7:0] dout_o
);

  byte_t sq;
  byte_t inv;

  // Inverse as x^254 = x^2 * x^4 * ... * x^128, then the affine transform.
  always_comb begin
    sq  = din_i;
    inv = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    dout_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/sbox_share_ctrl.sv
// sbox_share_ctrl: time-shares LANES S-box lanes between the round SubBytes
// path (16 bytes) and the key-schedule SubWord path (4 bytes).
module sbox_share_ctrl
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         st_valid,
  output logic         st_ready,
  input  logic [127:0] st_in,
  output logic         st_done,
  output logic [127:0] st_out,
  input  logic         wd_valid,
  output logic         wd_ready,
  input  logic [31:0]  wd_in,
  output logic         wd_done,
  output logic [31:0]  wd_out,
  output logic         busy
);

  localparam int ST_BEATS = NB_STATE_BYTES / LANES;
  localparam int WD_BEATS = NB_WORD_BYTES / LANES;
  localparam int CW       = (ST_BEATS > 2) ? $clog2(ST_BEATS) : 1;

  if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
    $error("sbox_share_ctrl: LANES must be 1, 2 or 4");
  end

  fsm_e                    state_q, state_d;
  rr_e                     rr_q, rr_d;
  logic [CW-1:0]           beat_q, beat_d;
  state_t                  st_work_q, st_work_d;
  word_t                   wd_work_q, wd_work_d;
  state_t                  st_out_q, st_out_d;
  word_t                   wd_out_q, wd_out_d;
  logic                    st_done_q, st_done_d;
  logic                    wd_done_q, wd_done_d;
  logic                    st_grant, wd_grant;
  logic [3:0]              st_base;
  logic [1:0]              wd_base;
  logic [LANES-1:0][7:0]   lane_in, lane_out;
  state_t                  st_wb;
  word_t                   wd_wb;

  assign st_base = 4'(32'(beat_q) * LANES);
  assign wd_base = 2'(32'(beat_q) * LANES);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign lane_in[g] = (state_q == WD_RUN) ? wd_work_q[wd_base + 2'(g)]
                                            : st_work_q[st_base + 4'(g)];
    subbyte u_subbyte (
      .din_i  (lane_in[g]),
      .dout_o (lane_out[g])
    );
  end

  // Work registers with this beat's lane results written back in place.
  always_comb begin
    st_wb = st_work_q;
    wd_wb = wd_work_q;
    for (int unsigned j = 0; j < LANES; j++) begin
      st_wb[st_base + 4'(j)] = lane_out[j];
      wd_wb[wd_base + 2'(j)] = lane_out[j];
    end
  end

  // Arbitration, beat sequencing and result capture.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    beat_d    = beat_q;
    st_work_d = st_work_q;
    wd_work_d = wd_work_q;
    st_out_d  = st_out_q;
    wd_out_d  = wd_out_q;
    st_done_d = 1'b0;
    wd_done_d = 1'b0;
    st_grant  = 1'b0;
    wd_grant  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (st_valid && (!wd_valid || rr_q == RR_STATE)) st_grant = 1'b1;
        else if (wd_valid)                               wd_grant = 1'b1;
        if (st_grant) begin
          state_d   = ST_RUN;
          st_work_d = st_in;
          beat_d    = '0;
          rr_d      = RR_WORD;
        end else if (wd_grant) begin
          state_d   = WD_RUN;
          wd_work_d = wd_in;
          beat_d    = '0;
          rr_d      = RR_STATE;
        end
      end
      ST_RUN: begin
        st_work_d = st_wb;
        beat_d    = beat_q + 1'b1;
        if (beat_q == CW'(ST_BEATS - 1)) begin
          st_out_d  = st_wb;
          st_done_d = 1'b1;
          state_d   = IDLE;
          beat_d    = '0;
        end
      end
      WD_RUN: begin
        wd_work_d = wd_wb;
        beat_d    = beat_q + 1'b1;
        if (beat_q == CW'(WD_BEATS - 1)) begin
          wd_out_d  = wd_wb;
          wd_done_d = 1'b1;
          state_d   = IDLE;
          beat_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_q      <= RR_WORD;
      beat_q    <= '0;
      st_work_q <= '0;
      wd_work_q <= '0;
      st_out_q  <= '0;
      wd_out_q  <= '0;
      st_done_q <= 1'b0;
      wd_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      beat_q    <= beat_d;
      st_work_q <= st_work_d;
      wd_work_q <= wd_work_d;
      st_out_q  <= st_out_d;
      wd_out_q  <= wd_out_d;
      st_done_q <= st_done_d;
      wd_done_q <= wd_done_d;
    end
  end

  assign st_ready = st_grant;
  assign wd_ready = wd_grant;
  assign st_done  = st_done_q;
  assign wd_done  = wd_done_q;
  assign st_out   = st_out_q;
  assign wd_out   = wd_out_q;
  assign busy     = (state_q != IDLE);

endmodule
